matrix_input_assembler: RTL
===========================

# matrix_input_assembler

Upstream framing stage for `matrix_storage`. It receives a raw byte stream from the UART receive front end and assembles each matrix frame into the packed store interface: dimensions plus 200-bit row-major data. It validates dimensions, element range, storage occupancy and inter-byte timeout, then issues a single-cycle `input_store_en`. Output ports connect one-to-one to `matrix_storage` `input_mat_m`, `input_mat_n`, `input_mat_data` and `input_store_en`.

## Interface
- `MAX_DIM`, 5, largest legal m or n; packed data capacity is `MAX_DIM*MAX_DIM*8` = 200 bits.
- `ELEM_MAX`, 9, largest legal element value.
- `MAX_MATS`, 10, storage capacity; at or above this the store is rejected.
- `TIMEOUT_CYC`, 100_000_000, idle cycles allowed between bytes inside a frame; counter is 27 bits.

Ports (reset is asynchronous, active-low):
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_data`  in  8  received byte, binary value.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid in this cycle.
- `cancel`  in  1  synchronous abort; returns to IDLE, no error.
- `mat_count`  in  4  `total_mat_count` from storage.
- `input_mat_m`  out  4  row count of the assembled matrix.
- `input_mat_n`  out  4  column count.
- `input_mat_data`  out  200  element k (row-major, k = r*n + c) at bits [8k+7:8k]; unused elements are 0.
- `input_store_en`  out  1  one-cycle store strobe.
- `busy`  out  1  high in every state except IDLE.
- `error_type`  out  3  one-cycle error code: 0 none, 1 bad dimension, 2 element > ELEM_MAX, 3 storage full, 4 timeout.

## Operation
- **States.** IDLE, GET_N, GET_ELEM, STORE.
- **IDLE.** On `rx_valid`, the byte is m.
  - If 1 ≤ m ≤ MAX_DIM: latch m, go to GET_N.
  - Otherwise: `error_type`=1, stay in IDLE.
- **GET_N.** On `rx_valid`, the byte is n.
  - If 1 ≤ n ≤ MAX_DIM: latch n, set total = m*n (5-bit), clear idx and `input_mat_data` to 0, go to GET_ELEM.
  - Otherwise: `error_type`=1, go to IDLE.
- **GET_ELEM.** On `rx_valid`:
  - If the byte > ELEM_MAX: `error_type`=2, go to IDLE; the partial frame is discarded.
  - Otherwise: write the byte to element idx and increment idx.
  - If idx == total-1 at acceptance: go to STORE.
- **STORE.** Lasts exactly one cycle.
  - If `mat_count` ≥ MAX_MATS: `error_type`=3, no strobe.
  - Otherwise: `input_store_en`=1.
  - Either way, go to IDLE.
- **Timeout.** An idle counter resets on every accepted byte and on entry to GET_N. If it reaches TIMEOUT_CYC in GET_N or GET_ELEM: `error_type`=4, go to IDLE.
- **`cancel`.** Highest priority. From any state, go to IDLE with no error and no strobe. A byte presented in the same cycle is dropped.
- **Dropped bytes.** `rx_valid` in STORE is dropped; the next frame starts with a fresh m byte.
- **Output holding.** `input_mat_m`, `input_mat_n` and `input_mat_data` update only as described above. They are otherwise held, and remain stable through and after the strobe.
- **Arithmetic.** m*n ≤ 25, so idx is 5 bits. Element write index is 8*idx.

## Timing
- **Reset values.** state IDLE; `input_mat_m`=0, `input_mat_n`=0, `input_mat_data`=0; `input_store_en`=0; `busy`=0; `error_type`=0; idx=0; timeout counter=0.
- **Strobe latency.** The last element is sampled at edge E0, STORE is occupied until E1, and `input_store_en` is high from E1 to E2 (exactly one cycle).
- **Frame length.** Minimum frame is 3 bytes (1×1). Back-to-back `rx_valid` every cycle is supported.
- **Error pulses.** `error_type` is registered and nonzero for exactly one cycle, asserted on the edge that samples the offending byte or condition.
- **Exclusivity.** `input_store_en` and a nonzero `error_type` are never high together.
- **`busy` timing.** `busy` rises on the edge that accepts m and falls on the edge returning to IDLE.
- **Reset mid-frame.** Immediate return to reset values; no strobe.

## Test plan
- **Basic 2×3 store.** Bytes 2,3,1,2,3,4,5,6, `mat_count`=0 → one `input_store_en` pulse two edges after the last byte. `input_mat_m`=2, `input_mat_n`=3. `input_mat_data[47:0]`=0x060504030201, upper bits 0.
- **Bad dimensions.** m=0 → `error_type`=1, `busy` stays 0. Then m=2, n=6 → `error_type`=1, state IDLE, no strobe.
- **Bad element.** 1,2,4,10 → `error_type`=2 on the edge sampling 10. A subsequent 1,1,7 stores a 1×1 matrix with data 0x07.
- **Storage full.** A full 5×5 frame of 9s with `mat_count`=10 → `error_type`=3, no strobe. The same frame with `mat_count`=9 → strobe, and all 25 bytes read 0x09.
- **Timeout.** 3,3,1, then silence for TIMEOUT_CYC cycles (bench override TIMEOUT_CYC=50) → `error_type`=4 at cycle 50, `busy` falls.
- **Cancel and reset mid-frame.** `cancel` after 2,2,1 → IDLE, no error. `rst_n` low after 2,2,1,1 → all outputs 0. A following 1,1,3 → strobe with data 0x03.

Source files
------------

// File: rtl/matrix_input_assembler.sv
// Frames a UART byte stream (m, n, then m*n elements) into the packed
// matrix_storage store interface, with dimension, range, occupancy and timeout checks.
module matrix_input_assembler #(
  parameter int MAX_DIM     = 5,
  parameter int ELEM_MAX    = 9,
  parameter int MAX_MATS    = 10,
  parameter int TIMEOUT_CYC = 100_000_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  input  logic                         cancel,
  input  logic [3:0]                   mat_count,
  output logic [3:0]                   input_mat_m,
  output logic [3:0]                   input_mat_n,
  output logic [MAX_DIM*MAX_DIM*8-1:0] input_mat_data,
  output logic                         input_store_en,
  output logic                         busy,
  output logic [2:0]                   error_type
);

  localparam int NELEM = MAX_DIM * MAX_DIM;
  localparam int IDX_W = $clog2(NELEM + 1);
  localparam int CNT_W = 27;

  localparam logic [7:0]       DIM_B   = 8'(MAX_DIM);
  localparam logic [7:0]       ELEM_B  = 8'(ELEM_MAX);
  localparam logic [3:0]       MATS_B  = 4'(MAX_MATS);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, GET_N, GET_ELEM, STORE} state_e;
  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_DIM     = 3'd1,
    ERR_ELEM    = 3'd2,
    ERR_FULL    = 3'd3,
    ERR_TIMEOUT = 3'd4
  } err_e;

  state_e                   state_q;
  err_e                     err_q;
  logic                     store_en_q;
  logic [3:0]               m_q, n_q;
  logic [NELEM*8-1:0]       data_q;
  logic [IDX_W-1:0]         idx_q, total_q;
  logic [CNT_W-1:0]         cnt_q;

  logic dim_ok;
  assign dim_ok = (rx_data != 8'd0) && (rx_data <= DIM_B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      err_q      <= ERR_NONE;
      store_en_q <= 1'b0;
      m_q        <= '0;
      n_q        <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      total_q    <= '0;
      cnt_q      <= '0;
    end else begin
      // NOTE: pulse outputs default low every cycle with non-blocking assignments,
      // so a later assignment in this block wins and no pulse can stick.
      store_en_q <= 1'b0;
      err_q      <= ERR_NONE;

      if (cancel) begin
        state_q <= IDLE;
        idx_q   <= '0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q <= '0;
            if (rx_valid) begin
              if (dim_ok) begin
                m_q     <= rx_data[3:0];
                state_q <= GET_N;
              end else begin
                err_q <= ERR_DIM;
              end
            end
          end

          GET_N: begin
            if (rx_valid) begin
              cnt_q <= '0;
              if (dim_ok) begin
                n_q     <= rx_data[3:0];
                total_q <= IDX_W'({4'b0, m_q} * {4'b0, rx_data[3:0]});
                idx_q   <= '0;
                data_q  <= '0;
                state_q <= GET_ELEM;
              end else begin
                err_q   <= ERR_DIM;
                state_q <= IDLE;
              end
            end else if (cnt_q == TO_LAST) begin
              err_q   <= ERR_TIMEOUT;
              cnt_q   <= '0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end

          GET_ELEM: begin
            if (rx_valid) begin
              cnt_q <= '0;
              if (rx_data > ELEM_B) begin
                err_q   <= ERR_ELEM;
                idx_q   <= '0;
                state_q <= IDLE;
              end else begin
                for (int k = 0; k < NELEM; k++) begin
                  if (idx_q == IDX_W'(k)) data_q[8*k +: 8] <= rx_data;
                end
                idx_q <= idx_q + IDX_W'(1);
                if (idx_q == total_q - IDX_W'(1)) state_q <= STORE;
              end
            end else if (cnt_q == TO_LAST) begin
              err_q   <= ERR_TIMEOUT;
              cnt_q   <= '0;
              idx_q   <= '0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end

          STORE: begin
            // Any byte arriving this cycle is ignored; the next frame restarts at m.
            if (mat_count >= MATS_B) err_q <= ERR_FULL;
            else                     store_en_q <= 1'b1;
            idx_q   <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign input_mat_m    = m_q;
  assign input_mat_n    = n_q;
  assign input_mat_data = data_q;
  assign input_store_en = store_en_q;
  assign error_type     = err_q;
  assign busy           = (state_q != IDLE);

endmodule
